// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave receiver.
// Contents: spi_state_t (IDLE/ACTIVE), default frame length SPI_DATA_W,
//           matching bit-counter width SPI_CNT_W.
package spi_pkg;

    localparam int unsigned SPI_DATA_W = 8;
    localparam int unsigned SPI_CNT_W  = $clog2(SPI_DATA_W);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Pin synchroniser with edge detection in the clk domain.
// Ports:
//   clk, rst  - system clock, async active-high reset
//   din       - asynchronous pin
//   rise_c    - one-cycle pulse on a synchronised 0->1 transition
//   fall_c    - one-cycle pulse on a synchronised 1->0 transition
// RST_VAL is the pin's idle level, so releasing reset creates no false edge.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchroniser chain plus one compare flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_c =  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_c = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave, fully oversampled in the clk domain.
// Deserialises DATA_W-bit words from MOSI into rx_data and serialises
// tx_data onto MISO; supports back-to-back words under one CS assertion.
// Ports:
//   clk, rst       - system clock, async active-high reset
//   clkSeq, CS     - SCLK (idle low) and active-low chip select from master
//   MOSI / MISO    - serial data in / out (MISO is 0 outside ACTIVE)
//   tx_data        - word to transmit, sampled at frame or word start
//   rx_data        - last complete received word
//   rx_valid       - one-cycle pulse when rx_data updates
//   busy           - high while a frame is active
//   frame_err      - one-cycle pulse when CS rises mid-word
// Build option: define SPI_SLAVE_LSB_FIRST_EN for LSB-first shifting
// (default is MSB first).
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = SPI_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clkSeq,
    input  logic              CS,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              frame_err
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    localparam int unsigned TX_BIT = 0;
`else
    localparam int unsigned TX_BIT = DATA_W - 1;
`endif

    logic sclk_rise_c, sclk_fall_c, cs_rise_c, cs_fall_c;
    logic [SYNC_STAGES-1:0] mosi_q;

    spi_state_t        state_q, state_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              reload_q, reload_d;
    logic              wrap_q, wrap_d;
    logic              err_d;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .din    (clkSeq),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_c)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .din    (CS),
        .rise_c (cs_rise_c),
        .fall_c (cs_fall_c)
    );

    // MOSI needs only its level, aligned with the SCLK edge pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_q <= '0;
        end else begin
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], MOSI};
        end
    end

    // Next-state and datapath; a CS rise takes priority over any SCLK edge.
    always_comb begin
        state_d   = state_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        bit_cnt_d = bit_cnt_q;
        reload_d  = reload_q;
        wrap_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall_c) begin
                    state_d   = ACTIVE;
                    tx_sr_d   = tx_data;
                    rx_sr_d   = '0;
                    bit_cnt_d = '0;
                    reload_d  = 1'b0;
                end
            end
            ACTIVE: begin
                if (cs_rise_c) begin
                    state_d  = IDLE;
                    reload_d = 1'b0;
                    if (bit_cnt_q != '0) begin
                        err_d   = 1'b1;
                        rx_sr_d = '0;
                    end
                end else begin
                    if (sclk_rise_c) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
                        rx_sr_d = {mosi_q[SYNC_STAGES-1], rx_sr_q[DATA_W-1:1]};
`else
                        rx_sr_d = {rx_sr_q[DATA_W-2:0], mosi_q[SYNC_STAGES-1]};
`endif
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            bit_cnt_d = '0;
                            wrap_d    = 1'b1;
                            reload_d  = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    if (sclk_fall_c) begin
                        // First fall after a completed word starts the next word.
                        if (reload_q) begin
                            tx_sr_d  = tx_data;
                            reload_d = 1'b0;
                        end else begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
                            tx_sr_d = {1'b0, tx_sr_q[DATA_W-1:1]};
`else
                            tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
`endif
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            bit_cnt_q <= '0;
            reload_q  <= 1'b0;
            wrap_q    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            MISO      <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            bit_cnt_q <= bit_cnt_d;
            reload_q  <= reload_d;
            wrap_q    <= wrap_d;
            // rx_sr already holds the full word one cycle after the wrap.
            rx_valid  <= wrap_q;
            if (wrap_q) begin
                rx_data <= rx_sr_q;
            end
            busy      <= (state_d == ACTIVE);
            frame_err <= err_d;
            MISO      <= (state_q == ACTIVE) ? tx_sr_q[TX_BIT] : 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: acts as a mode-0 SPI master and
// compares received words, returned MISO words and status pulses with
// expectations derived from the transmitted words.
module tb_spi_slave_rx;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int          HP          = SYNC_STAGES + 6;   // SCLK half-period in clk cycles
    localparam int          LAT         = SYNC_STAGES + 2;   // last SCLK rise to rx_valid

    logic              clk = 1'b0;
    logic              rst;
    logic              clkSeq, CS, MOSI, MISO;
    logic [DATA_W-1:0] tx_data, rx_data;
    logic              rx_valid, busy, frame_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int valid_cyc = 0;
    int rise_cyc = 0;
    logic [DATA_W-1:0] got_q[$];
    logic [DATA_W-1:0] mosi_w[0:3];
    logic [DATA_W-1:0] tx_w[0:4];
    logic [DATA_W-1:0] last_rx = '0;

    spi_slave_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .clkSeq    (clkSeq),
        .CS        (CS),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every status pulse; a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                valid_cnt = valid_cnt + 1;
                valid_cyc = cyc;
                got_q.push_back(rx_data);
            end
            if (frame_err) err_cnt = err_cnt + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift nbits of w out on MOSI and collect MISO at each SCLK rise.
    // tx_data switches to next_tx after the last rise; cs_end raises CS
    // together with the final SCLK fall.
    task automatic send_bits(input logic [DATA_W-1:0] w, input int nbits,
                             input logic [DATA_W-1:0] next_tx, input bit cs_end,
                             output logic [DATA_W-1:0] seen);
        seen = '0;
        for (int i = 0; i < nbits; i++) begin
            int idx;
`ifdef SPI_SLAVE_LSB_FIRST_EN
            idx = i;
`else
            idx = DATA_W - 1 - i;
`endif
            MOSI = w[idx];
            wait_n(HP);
            seen[idx] = MISO;
            clkSeq = 1'b1;
            rise_cyc = cyc;
            if (i == nbits - 1) tx_data = next_tx;
            wait_n(HP);
            clkSeq = 1'b0;
            if (cs_end && i == nbits - 1) CS = 1'b1;
        end
    endtask

    // Full frame of nw words mosi_w[], answering with tx_w[].
    task automatic run_frame(input int nw, input bit cs_with_fall);
        logic [DATA_W-1:0] seen;
        logic [31:0] g;
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        got_q.delete();
        tx_data = tx_w[0];
        CS = 1'b0;
        wait_n(HP);
        check_eq("busy_active", 32'(busy), 32'd1);
        for (int k = 0; k < nw; k++) begin
            send_bits(mosi_w[k], DATA_W, tx_w[k+1], cs_with_fall && (k == nw - 1), seen);
            check_eq("miso_word", 32'(seen), 32'(tx_w[k]));
        end
        if (!cs_with_fall) begin
            wait_n(HP);
            CS = 1'b1;
        end
        wait_n(HP);
        check_eq("valid_count", 32'(valid_cnt - v0), 32'(nw));
        check_eq("err_count", 32'(err_cnt - e0), 32'd0);
        check_eq("valid_latency", 32'(valid_cyc - rise_cyc), 32'(LAT));
        for (int k = 0; k < nw; k++) begin
            g = (k < got_q.size()) ? 32'(got_q[k]) : 32'hDEAD_BEEF;
            check_eq("rx_word", g, 32'(mosi_w[k]));
        end
        check_eq("rx_data_hold", 32'(rx_data), 32'(mosi_w[nw-1]));
        check_eq("busy_idle", 32'(busy), 32'd0);
        check_eq("miso_idle", 32'(MISO), 32'd0);
        last_rx = mosi_w[nw-1];
    endtask

    // CS raised after k SCLK rises: error only for a partial word.
    task automatic abort_frame(input int k);
        logic [DATA_W-1:0] seen;
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        tx_data = DATA_W'($urandom);
        CS = 1'b0;
        wait_n(HP);
        send_bits(DATA_W'($urandom), k, tx_data, 1'b0, seen);
        wait_n(HP);
        CS = 1'b1;
        wait_n(2 * HP);
        check_eq("abort_err", 32'(err_cnt - e0), (k % DATA_W != 0) ? 32'd1 : 32'd0);
        check_eq("abort_valid", 32'(valid_cnt - v0), 32'd0);
        check_eq("abort_rx_data", 32'(rx_data), 32'(last_rx));
    endtask

    // Reset asserted after 4 bits: outputs clear at once, no pulses follow.
    task automatic reset_mid_frame();
        logic [DATA_W-1:0] seen;
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        tx_data = 8'hFF;
        CS = 1'b0;
        wait_n(HP);
        send_bits(8'hA5, 4, tx_data, 1'b0, seen);
        MOSI = 1'b1;
        clkSeq = 1'b1;
        wait_n(2);
        rst = 1'b1;
        #1;
        check_eq("rst_miso", 32'(MISO), 32'd0);
        check_eq("rst_rx_data", 32'(rx_data), 32'd0);
        check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_frame_err", 32'(frame_err), 32'd0);
        wait_n(2);
        CS = 1'b1;
        clkSeq = 1'b0;
        wait_n(1);
        rst = 1'b0;
        wait_n(2 * HP);
        check_eq("rst_no_err", 32'(err_cnt - e0), 32'd0);
        check_eq("rst_no_valid", 32'(valid_cnt - v0), 32'd0);
        last_rx = '0;
    endtask

    initial begin
        int nw;
        rst = 1'b1;
        clkSeq = 1'b0;
        CS = 1'b1;
        MOSI = 1'b0;
        tx_data = '0;
        wait_n(3);
        check_eq("reset_miso", 32'(MISO), 32'd0);
        check_eq("reset_rx_data", 32'(rx_data), 32'd0);
        check_eq("reset_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        wait_n(4);

        // Single word 0xAA answered with 0x01.
        mosi_w[0] = 8'hAA; tx_w[0] = 8'h01; tx_w[1] = 8'h00;
        run_frame(1, 1'b0);

        // Back-to-back 0x3C, 0xC3 with tx_data 0x01 then 0x80.
        mosi_w[0] = 8'h3C; mosi_w[1] = 8'hC3;
        tx_w[0] = 8'h01; tx_w[1] = 8'h80; tx_w[2] = 8'h00;
        run_frame(2, 1'b0);

        // Partial word, then a clean 0x55 frame.
        abort_frame(5);
        mosi_w[0] = 8'h55; tx_w[0] = DATA_W'($urandom); tx_w[1] = '0;
        run_frame(1, 1'b0);

        // Reset mid-frame, then 0x0F.
        reset_mid_frame();
        mosi_w[0] = 8'h0F; tx_w[0] = DATA_W'($urandom); tx_w[1] = '0;
        run_frame(1, 1'b0);

        // CS pulsed with no clocks is not an error.
        abort_frame(0);

        // Randomised frames and aborts.
        for (int r = 0; r < 24; r++) begin
            nw = $urandom_range(1, 4);
            for (int k = 0; k < 4; k++) mosi_w[k] = DATA_W'($urandom);
            for (int k = 0; k < 5; k++) tx_w[k] = DATA_W'($urandom);
            run_frame(nw, 1'($urandom_range(0, 1)));
            if (r % 4 == 3) abort_frame($urandom_range(1, DATA_W - 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
